// File: rtl/word_capture_pkg.sv
// rtl/word_capture_pkg.sv - shared types and defaults for the word capture sink
package word_capture_pkg;

   typedef enum logic [1:0] {
      CAPTURE = 2'd0,
      DUMP    = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam int DATA_W_DEFAULT = 32;

endpackage

// File: rtl/word_capture_ram.sv
// rtl/word_capture_ram.sv - simple dual-port RAM, one write port, one read port, 1-cycle read
module capture_ram
   import word_capture_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // rdata holds its value while re is low; the top uses it as the replay register
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/word_capture.sv
// rtl/word_capture.sv - captures a word stream into a buffer and replays it on request
module word_capture
   import word_capture_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              dump_req,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              dump_done,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              overflow
);

   localparam int            DEPTH     = 2**ADDR_W;
   localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   wr_ptr;
   logic [ADDR_W:0]     rd_cnt;
   logic [DATA_W-1:0]   rdata;
   logic                wr_fire, rd_fire, out_fire, all_issued;

   assign full       = (count == DEPTH_CNT);
   assign all_issued = (rd_cnt == count);
   assign out_fire   = out_valid && out_ready;
   assign out_data   = out_valid ? rdata : '0;

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      wr_fire   = 1'b0;
      rd_fire   = 1'b0;
      dump_done = 1'b0;
      unique case (state)
         CAPTURE: begin
            in_ready = !full && !reset;
            wr_fire  = in_valid && in_ready;
            // a word written alongside dump_req still counts towards the dump
            if (dump_req) state_nxt = ((count != '0) || wr_fire) ? DUMP : DONE;
         end
         DUMP: begin
            // refill the output register whenever it is empty or draining this cycle
            rd_fire = !all_issued && (!out_valid || out_ready);
            if (all_issued && out_fire) state_nxt = DONE;
         end
         DONE: begin
            dump_done = 1'b1;
            state_nxt = CAPTURE;
         end
         default: state_nxt = CAPTURE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= CAPTURE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset || state == DONE) begin
         wr_ptr    <= '0;
         rd_cnt    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (wr_fire) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            count  <= count + CNT_ONE;
         end
         if (state == CAPTURE && in_valid && full) overflow <= 1'b1;
         if (rd_fire) begin
            rd_cnt    <= rd_cnt + CNT_ONE;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   capture_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
      .clk   (clk),
      .we    (wr_fire),
      .waddr (wr_ptr),
      .wdata (in_data),
      .re    (rd_fire),
      .raddr (rd_cnt[ADDR_W-1:0]),
      .rdata (rdata)
   );

endmodule
